// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Imported by the arbiter top and its round-robin picker.
package seg_disp_pkg;

  localparam int ID_W   = 2;
  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] BLANK_WORD = 16'h0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  function automatic logic [3:0] id_to_onehot(input logic [ID_W-1:0] id);
    return 4'b0001 << id;
  endfunction

endpackage

// File: rtl/seg_rr_pick.sv
// Combinational round-robin picker: searches from last_owner+1 upward with wrap,
// ignoring any requester set in the exclude mask.
module seg_rr_pick
  import seg_disp_pkg::*;
(
  input  logic [3:0]      req,
  input  logic [ID_W-1:0] last_owner,
  input  logic [3:0]      exclude,
  output logic            found,
  output logic [ID_W-1:0] winner
);

  logic [3:0]      cand;
  logic [3:0]      rot_req;
  logic [ID_W-1:0] offset;

  assign cand = req & ~exclude;

  // rot_req[0] is the highest-priority candidate (last_owner+1), rot_req[3] the lowest.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign rot_req[gi] = cand[ID_W'(last_owner + ID_W'(gi + 1))];
  end

  always_comb begin
    offset = '0;
    for (int i = 3; i >= 0; i--) begin
      if (rot_req[i]) offset = ID_W'(i);
    end
  end

  assign found  = |rot_req;
  assign winner = last_owner + ID_W'(1) + offset;

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the 4-digit display with minimum dwell per owner and a
// one-cycle blank gap between owners so grants never overlap.
module seg_display_arbiter
  import seg_disp_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TICK_DIV    = 100000,
  parameter int DWELL_TICKS = 500
) (
  input  logic                      clock_in,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [ID_W-1:0]           owner_id,
  output logic [DATA_W-1:0]         data_out,
  output logic                      display_en
);

  localparam int TICK_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DWELL_W = $clog2(DWELL_TICKS + 1);

  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL_TICKS);
  localparam logic [DWELL_W-1:0] DWELL_PRE = DWELL_W'(DWELL_TICKS - 1);

  state_t              state_reg, state_next;
  logic [ID_W-1:0]     owner_reg, owner_next;
  logic [ID_W-1:0]     last_owner_reg, last_owner_next;
  logic [TICK_W-1:0]   tick_cnt_reg, tick_cnt_next;
  logic [DWELL_W-1:0]  dwell_cnt_reg, dwell_cnt_next;
  logic [NUM_REQ-1:0]  grant_reg, grant_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                en_reg, en_next;

  logic [DATA_W-1:0]   slice_word [NUM_REQ];
  logic                tick_now;
  logic                expired;
  logic [ID_W-1:0]     pick_last;
  logic [3:0]          pick_excl;
  logic                pick_found;
  logic [ID_W-1:0]     pick_winner;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign slice_word[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // While ACTIVE the picker answers "is anyone other than the owner waiting";
  // otherwise it performs the real round-robin selection.
  assign pick_last = (state_reg == ACTIVE) ? owner_reg : last_owner_reg;
  assign pick_excl = (state_reg == ACTIVE) ? id_to_onehot(owner_reg) : 4'b0000;

  seg_rr_pick u_pick (
    .req        (req),
    .last_owner (pick_last),
    .exclude    (pick_excl),
    .found      (pick_found),
    .winner     (pick_winner)
  );

  // Expiry includes the tick landing on this edge, so ownership lasts exactly
  // DWELL_TICKS*TICK_DIV cycles before a waiting requester takes over.
  assign tick_now = (tick_cnt_reg == TICK_LAST);
  assign expired  = (dwell_cnt_reg == DWELL_MAX) ||
                    (tick_now && (dwell_cnt_reg == DWELL_PRE));

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    tick_cnt_next   = '0;
    dwell_cnt_next  = '0;
    grant_next      = '0;
    data_next       = BLANK_WORD;
    en_next         = 1'b0;

    case (state_reg)
      IDLE, GAP: begin
        if (pick_found) begin
          state_next = ACTIVE;
          owner_next = pick_winner;
          grant_next = id_to_onehot(pick_winner);
          data_next  = slice_word[pick_winner];
          en_next    = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end

      ACTIVE: begin
        if (!req[owner_reg] || (expired && pick_found)) begin
          state_next      = GAP;
          last_owner_next = owner_reg;
        end else begin
          grant_next     = id_to_onehot(owner_reg);
          data_next      = slice_word[owner_reg];
          en_next        = 1'b1;
          tick_cnt_next  = tick_now ? '0 : tick_cnt_reg + 1'b1;
          dwell_cnt_next = (tick_now && dwell_cnt_reg != DWELL_MAX) ?
                           dwell_cnt_reg + 1'b1 : dwell_cnt_reg;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      last_owner_reg <= ID_W'(3);
      tick_cnt_reg   <= '0;
      dwell_cnt_reg  <= '0;
      grant_reg      <= '0;
      data_reg       <= BLANK_WORD;
      en_reg         <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      tick_cnt_reg   <= tick_cnt_next;
      dwell_cnt_reg  <= dwell_cnt_next;
      grant_reg      <= grant_next;
      data_reg       <= data_next;
      en_reg         <= en_next;
    end
  end

  assign grant      = grant_reg;
  assign owner_id   = owner_reg;
  assign data_out   = data_reg;
  assign display_en = en_reg;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with TICK_DIV=4, DWELL_TICKS=3 (12-cycle dwell).
module tb_seg_display_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  grant;
  logic [1:0]  owner_id;
  logic [15:0] data_out;
  logic        display_en;

  int checks = 0;
  int errors = 0;

  seg_display_arbiter #(
    .NUM_REQ     (4),
    .TICK_DIV    (4),
    .DWELL_TICKS (3)
  ) dut (
    .clock_in   (clk),
    .reset      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .owner_id   (owner_id),
    .data_out   (data_out),
    .display_en (display_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and land 1 ns after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_slice(input int idx, input logic [15:0] val);
    req_data[idx*16 +: 16] = val;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    logic [3:0] exp_g;
    rst_n    = 1'b0;
    req      = 4'b0000;
    req_data = 64'h0;

    // Reset state
    step(2);
    chk("rst_grant", {28'h0, grant}, 32'h0);
    chk("rst_owner", {30'h0, owner_id}, 32'h0);
    chk("rst_data", {16'h0, data_out}, 32'h0);
    chk("rst_en", {31'h0, display_en}, 32'h0);
    rst_n = 1'b1;
    step(1);

    // Single request, one-cycle latency
    req = 4'b0100;
    set_slice(2, 16'h1234);
    chk("single_pre_grant", {28'h0, grant}, 32'h0);
    step(1);
    chk("single_grant", {28'h0, grant}, 32'h4);
    chk("single_owner", {30'h0, owner_id}, 32'h2);
    chk("single_data", {16'h0, data_out}, 32'h1234);
    chk("single_en", {31'h0, display_en}, 32'h1);
    $display("txn single: grant=%b owner=%0d data=%h", grant, owner_id, data_out);

    // Simultaneous requests: 0,1,2,3,0 each 12 cycles with one gap cycle
    do_reset();
    for (int i = 0; i < 4; i++) set_slice(i, 16'hA000 + 16'(i));
    req = 4'b1111;
    step(1);
    for (int k = 0; k < 4; k++) begin
      exp_g = 4'b0001 << k;
      chk("rr_owner", {30'h0, owner_id}, 32'(k));
      chk("rr_data", {16'h0, data_out}, 32'h0000A000 + 32'(k));
      for (int c = 0; c < 12; c++) begin
        chk("rr_hold", {28'h0, grant}, {28'h0, exp_g});
        step(1);
      end
      chk("rr_gap_grant", {28'h0, grant}, 32'h0);
      chk("rr_gap_en", {31'h0, display_en}, 32'h0);
      chk("rr_gap_data", {16'h0, data_out}, 32'h0);
      $display("txn rr: owner %0d released after 12 cycles", k);
      step(1);
    end
    chk("rr_wrap_grant", {28'h0, grant}, 32'h1);
    chk("rr_wrap_owner", {30'h0, owner_id}, 32'h0);

    // Dwell hold: owner 1, requester 3 arrives 2 cycles later
    do_reset();
    req = 4'b0010;
    step(1);
    chk("dwell_first", {28'h0, grant}, 32'h2);
    step(2);
    req = 4'b1010;
    for (int c = 2; c < 12; c++) begin
      chk("dwell_hold", {28'h0, grant}, 32'h2);
      step(1);
    end
    chk("dwell_gap", {28'h0, grant}, 32'h0);
    step(1);
    chk("dwell_next", {28'h0, grant}, 32'h8);
    chk("dwell_next_owner", {30'h0, owner_id}, 32'h3);
    $display("txn dwell: grant=%b owner=%0d", grant, owner_id);

    // Early release: owner 0 drops at cycle 5, requester 2 waiting
    do_reset();
    set_slice(2, 16'h5A5A);
    req = 4'b0101;
    step(1);
    chk("early_first", {28'h0, grant}, 32'h1);
    step(5);
    chk("early_c5", {28'h0, grant}, 32'h1);
    req = 4'b0100;
    step(1);
    chk("early_gap", {28'h0, grant}, 32'h0);
    chk("early_gap_en", {31'h0, display_en}, 32'h0);
    step(1);
    chk("early_next", {28'h0, grant}, 32'h4);
    chk("early_next_data", {16'h0, data_out}, 32'h5A5A);
    $display("txn early: grant=%b data=%h", grant, data_out);

    // Sole owner past expiry, live data update
    do_reset();
    set_slice(3, 16'hBEEF);
    req = 4'b1000;
    step(1);
    chk("sole_data0", {16'h0, data_out}, 32'hBEEF);
    for (int c = 0; c < 50; c++) begin
      chk("sole_hold", {28'h0, grant}, 32'h8);
      if (c == 30) begin
        set_slice(3, 16'hCAFE);
        chk("sole_data_before", {16'h0, data_out}, 32'hBEEF);
      end
      if (c == 31) chk("sole_data_after", {16'h0, data_out}, 32'hCAFE);
      step(1);
    end
    chk("sole_en", {31'h0, display_en}, 32'h1);
    $display("txn sole: grant=%b data=%h", grant, data_out);

    // Asynchronous reset mid-ownership
    rst_n = 1'b0;
    #2;
    chk("async_grant", {28'h0, grant}, 32'h0);
    chk("async_data", {16'h0, data_out}, 32'h0);
    chk("async_en", {31'h0, display_en}, 32'h0);
    step(1);
    req = 4'b0001;
    set_slice(0, 16'h0F0F);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_grant", {28'h0, grant}, 32'h1);
    chk("post_rst_owner", {30'h0, owner_id}, 32'h0);
    chk("post_rst_data", {16'h0, data_out}, 32'h0F0F);
    $display("txn reset: grant=%b owner=%0d data=%h", grant, owner_id, data_out);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
